// File: rtl/mux_clock_display.sv
// Time-multiplexed seven-segment driver for NUM_FIELDS two-digit decimal fields.
// Fields are double-buffered so the digits only change at a frame wrap, never mid-scan.
module mux_clock_display #(
   parameter int NUM_FIELDS     = 3,
   parameter int SCAN_DIV       = 1000,
   parameter int BLINK_FRAMES   = 64,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [7*NUM_FIELDS-1:0] i_fields_in,
   input  logic                    i_load,
   input  logic [NUM_FIELDS-1:0]   i_blink_mask,
   input  logic                    i_lz_blank,
   output logic [6:0]              o_seg,
   output logic                    o_dp,
   output logic [2*NUM_FIELDS-1:0] o_dig_en,
   output logic                    o_frame_done
);

   localparam int NUM_DIGITS = 2 * NUM_FIELDS;
   localparam int PW         = $clog2(SCAN_DIV);
   localparam int IW         = $clog2(NUM_DIGITS);
   localparam int BW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic ACT_LOW  = 1'(SEG_ACTIVE_LOW);

   function automatic logic [6:0] seg_pat(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   logic [PW-1:0]           r_presc;
   logic [IW-1:0]           r_idx;
   logic [7*NUM_FIELDS-1:0] r_pending;
   logic [7*NUM_FIELDS-1:0] r_active;
   logic [BW-1:0]           r_blink_cnt;
   logic                    r_phase;
   logic                    r_frame_done;
   logic [6:0]              r_seg;
   logic                    r_dp;
   logic [NUM_DIGITS-1:0]   r_dig_en;

   logic                    w_tc;
   logic                    w_frame;
   logic [IW-1:0]           w_k;
   logic                    w_ones;
   logic [6:0]              w_v;
   logic                    w_blink;
   logic [3:0]              w_digit;
   logic [6:0]              w_seg;
   logic                    w_dp;
   logic [NUM_DIGITS-1:0]   w_dig_en;
   logic [6:0]              w_field [NUM_FIELDS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
         assign w_field[gi] = r_active[7*gi +: 7];
      end
   endgenerate

   assign w_tc    = (r_presc == PW'(SCAN_DIV - 1));
   assign w_frame = w_tc && (r_idx == IW'(NUM_DIGITS - 1));

   // Each field owns two adjacent digits: even index = ones, odd index = tens.
   always_comb begin
      w_k      = r_idx >> 1;
      w_ones   = ~r_idx[0];
      w_v      = '0;
      w_blink  = 1'b0;
      for (int i = 0; i < NUM_FIELDS; i++) begin
         if (w_k == IW'(i)) begin
            w_v     = w_field[i];
            w_blink = i_blink_mask[i];
         end
      end
      w_digit  = w_ones ? 4'(w_v % 7'd10) : 4'(w_v / 7'd10);
      w_dp     = w_ones && (w_k != '0);
      if (w_v >= 7'd100) begin
         w_seg = 7'h40;
      end else if (!w_ones && i_lz_blank && (r_idx == IW'(NUM_DIGITS - 1)) && (w_v < 7'd10)) begin
         w_seg = 7'h00;
      end else begin
         w_seg = seg_pat(w_digit);
      end
      if (w_blink && r_phase) begin
         w_seg = 7'h00;
         w_dp  = 1'b0;
      end
      w_dig_en = NUM_DIGITS'(1) << r_idx;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_presc      <= '0;
         r_idx        <= '0;
         r_pending    <= '0;
         r_active     <= '0;
         r_blink_cnt  <= '0;
         r_phase      <= 1'b0;
         r_frame_done <= 1'b0;
         r_seg        <= '0;
         r_dp         <= 1'b0;
         r_dig_en     <= '0;
      end else begin
         r_presc      <= w_tc ? '0 : r_presc + 1'b1;
         if (w_tc) begin
            r_idx <= w_frame ? '0 : r_idx + 1'b1;
         end
         r_frame_done <= w_frame;
         if (i_load) begin
            r_pending <= i_fields_in;
         end
         // A load landing on the wrap cycle bypasses pending so it shows in the very next frame.
         if (w_frame) begin
            r_active <= i_load ? i_fields_in : r_pending;
            if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
               r_blink_cnt <= '0;
               r_phase     <= ~r_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + 1'b1;
            end
         end
         r_seg        <= w_seg;
         r_dp         <= w_dp;
         r_dig_en     <= w_dig_en;
      end
   end

   assign o_seg        = r_seg ^ {7{ACT_LOW}};
   assign o_dp         = r_dp ^ ACT_LOW;
   assign o_dig_en     = r_dig_en ^ {NUM_DIGITS{ACT_LOW}};
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_mux_clock_display.sv
// Bench for mux_clock_display: an active-high and an active-low instance share stimulus
// and are checked every cycle against a cycle-count based reference model.
module tb_mux_clock_display;

   localparam int NF    = 3;
   localparam int SD    = 4;
   localparam int BF    = 2;
   localparam int ND    = 2 * NF;
   localparam int FRAME = SD * ND;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load = 1'b0;
   logic          lz = 1'b0;
   logic [7*NF-1:0] fields = '0;
   logic [NF-1:0] mask = '0;

   logic [6:0]    seg_h, seg_l;
   logic          dp_h, dp_l, fd_h, fd_l;
   logic [ND-1:0] en_h, en_l;

   mux_clock_display #(.NUM_FIELDS(NF), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .SEG_ACTIVE_LOW(0)) dut_h (
      .i_clk(clk), .i_rst(rst), .i_fields_in(fields), .i_load(load), .i_blink_mask(mask),
      .i_lz_blank(lz), .o_seg(seg_h), .o_dp(dp_h), .o_dig_en(en_h), .o_frame_done(fd_h));

   mux_clock_display #(.NUM_FIELDS(NF), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .SEG_ACTIVE_LOW(1)) dut_l (
      .i_clk(clk), .i_rst(rst), .i_fields_in(fields), .i_load(load), .i_blink_mask(mask),
      .i_lz_blank(lz), .o_seg(seg_l), .o_dp(dp_l), .o_dig_en(en_l), .o_frame_done(fd_l));

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int n = 0;
   int f = 0;
   int pend [NF];
   int act [NF];
   int pat [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, n);
      end
   endtask

   // Expected outputs after the coming edge follow from the pre-edge cycle count n and frame count f.
   task automatic tick();
      int idx, k, v;
      logic [6:0] eseg;
      logic       edp, efd, ph, bnd;
      logic [ND-1:0] een;
      if (rst) begin
         eseg = '0; edp = 1'b0; een = '0; efd = 1'b0;
         n = 0; f = 0;
         foreach (pend[i]) begin pend[i] = 0; act[i] = 0; end
      end else begin
         ph  = ((f / BF) % 2) == 1;
         idx = (n / SD) % ND;
         k   = idx / 2;
         v   = act[k];
         if (v >= 100) eseg = 7'h40;
         else if ((idx % 2 == 1) && lz && (k == NF - 1) && (v < 10)) eseg = 7'h00;
         else eseg = 7'(pat[(idx % 2 == 0) ? v % 10 : v / 10]);
         edp = (idx % 2 == 0) && (k >= 1);
         if (mask[k] && ph) begin eseg = 7'h00; edp = 1'b0; end
         een = ND'(1) << idx;
         bnd = ((n + 1) % FRAME) == 0;
         efd = bnd;
         if (load) for (int i = 0; i < NF; i++) pend[i] = int'(fields[7*i +: 7]);
         if (bnd) begin act = pend; f++; end
         n++;
      end
      @(posedge clk);
      #1;
      chk("seg", {1'b0, seg_h}, {1'b0, eseg});
      chk("dp", {7'b0, dp_h}, {7'b0, edp});
      chk("dig_en", {2'b0, en_h}, {2'b0, een});
      chk("frame_done", {7'b0, fd_h}, {7'b0, efd});
      chk("seg_low", {1'b0, seg_l}, {1'b0, ~eseg});
      chk("dp_low", {7'b0, dp_l}, {7'b0, ~edp});
      chk("dig_en_low", {2'b0, en_l}, {2'b0, ~een});
      chk("frame_done_low", {7'b0, fd_l}, {7'b0, efd});
   endtask

   task automatic run(input int cyc);
      for (int i = 0; i < cyc; i++) tick();
   endtask

   task automatic do_load(input int a2, input int a1, input int a0);
      fields = {7'(a2), 7'(a1), 7'(a0)};
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   initial begin
      // reset held three cycles, then scan {23,59,07}
      run(3);
      rst = 1'b0;
      run(5);
      do_load(23, 59, 7);
      run(2 * FRAME);
      // mid-frame load, then a load exactly on the wrap cycle
      run(7);
      do_load(12, 34, 56);
      run(FRAME);
      while (((n + 1) % FRAME) != 0) tick();
      do_load(45, 1, 99);
      run(FRAME + 3);
      // leading-zero blank and out-of-range dash
      lz = 1'b1;
      do_load(5, 100, 8);
      run(2 * FRAME);
      lz = 1'b0;
      run(FRAME);
      // blink on field 1 across six frames
      mask = 3'b010;
      do_load(11, 22, 33);
      run(6 * FRAME);
      mask = '0;
      // reset in the middle of a frame
      run(9);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      run(2 * FRAME + 5);
      // randomized traffic
      for (int it = 0; it < 1500; it++) begin
         if ($urandom_range(0, 9) == 0) begin
            for (int i = 0; i < NF; i++)
               fields[7*i +: 7] = ($urandom_range(0, 5) == 0) ? 7'($urandom_range(100, 127))
                                                              : 7'($urandom_range(0, 99));
         end
         load = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 99) == 0) mask = NF'($urandom_range(0, 7));
         if ($urandom_range(0, 99) == 0) lz = ~lz;
         rst = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0;
      load = 1'b0;
      run(FRAME);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
